mem_port_arbiter: RTL

Two-requester arbiter and sequencer that shares one single-ported memory interface between the instruction-cache refill path and the scalar core's data path. It sits between `INSTR_CACHE`/`SCALAR_CORE` and the external memory port in the CPU top. It latches one request at a time, holds the address, write data and write enable stable until the memory handshakes, and returns the read data to the winning requester. A bounded-wait timeout ensures that a missing memory response cannot hang either requester.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory interface between the instruction-cache
//   refill path and the scalar core data path. One transaction is accepted
//   at a time. Its address, write data and write enable are held stable
//   until the memory handshakes. The read data is then returned to the
//   winning requester.
//
//   A bounded wait of MaxWait ACCESS cycles aborts a transaction that gets
//   no response from memory. The aborted transaction completes with err_o
//   set and read data of zero.
//
//   Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : round-robin arbitration under contention (data favoured
//                 after reset)
//     undefined : fixed priority, data always wins contention
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ireq_i/iaddr_i                instruction refill request
//   irdata_o/iready_o             instruction refill response
//   dreq_i/dwrite_i/daddr_i/
//   dwdata_i                      data request
//   drdata_o/dready_o             data response
//   mem_req_o/mem_write_o/
//   mem_addr_o/mem_wdata_o        memory request side
//   mem_rdata_i/mem_ready_i       memory response side
//   busy_o                        high in ACCESS and RESP
//   gnt_d_o                       current/last grant (1 = data)
//   err_o                         timeout flag, coincident with ready pulse
//
// All outputs come straight from registers.
module mem_port_arbiter #(
  parameter int DWidth  = 32,
  parameter int MaxWait = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_i,
  input  logic [DWidth-1:0] iaddr_i,
  output logic [DWidth-1:0] irdata_o,
  output logic              iready_o,
  input  logic              dreq_i,
  input  logic              dwrite_i,
  input  logic [DWidth-1:0] daddr_i,
  input  logic [DWidth-1:0] dwdata_i,
  output logic [DWidth-1:0] drdata_o,
  output logic              dready_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [DWidth-1:0] mem_addr_o,
  output logic [DWidth-1:0] mem_wdata_o,
  input  logic [DWidth-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              gnt_d_o,
  output logic              err_o
);

  // The wait counter only has to reach MaxWait-1.
  localparam int CW = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [CW-1:0] CntLast = CW'(MaxWait - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DWidth-1:0] rdata;
  logic              any_req;
  logic              grant_d;

  assign any_req = ireq_i | dreq_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prefer_d = 1 means data wins the next contention. The pointer moves
  // on every grant, contended or not, so it always points away from the
  // requester that was served last.
  logic prefer_d;

  assign grant_d = dreq_i & (~ireq_i | prefer_d);

  always_ff @(posedge clk_i) begin
    if (rst_i)                         prefer_d <= 1'b1;
    else if (state == IDLE && any_req) prefer_d <= ~grant_d;
  end
`else
  assign grant_d = dreq_i;
`endif

  // Both read-data outputs carry the same latched register. Each one is
  // only meaningful during its owner's ready pulse.
  assign irdata_o = rdata;
  assign drdata_o = rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      mem_req_o   <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      iready_o    <= 1'b0;
      dready_o    <= 1'b0;
      busy_o      <= 1'b0;
      gnt_d_o     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d_o     <= grant_d;
            mem_addr_o  <= grant_d ? daddr_i  : iaddr_i;
            mem_wdata_o <= grant_d ? dwdata_i : '0;
            mem_write_o <= grant_d & dwrite_i;  // instruction grants always read
            cnt         <= '0;
            mem_req_o   <= 1'b1;
            busy_o      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // A response that arrives on the last allowed cycle still counts
          // as a success, so mem_ready_i is tested before the timeout.
          if (mem_ready_i) begin
            rdata     <= mem_rdata_i;
            mem_req_o <= 1'b0;
            iready_o  <= ~gnt_d_o;
            dready_o  <= gnt_d_o;
            state     <= RESP;
          end else if (cnt == CntLast) begin
            rdata     <= '0;
            err_o     <= 1'b1;
            mem_req_o <= 1'b0;
            iready_o  <= ~gnt_d_o;
            dready_o  <= gnt_d_o;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Requests are not sampled here. A request still held in the
          // following IDLE cycle is treated as a new transaction.
          iready_o <= 1'b0;
          dready_o <= 1'b0;
          err_o    <= 1'b0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
